// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences the 3x3 convolution datapath over every 26x26 output position
module conv_ctrl #(
    parameter int IMG_W = 28,
    parameter int OUT_W = 26,
    parameter int WBASE = 784
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic [6:0]  cmd_flags,
    output logic [3:0]  tap,
    output logic [4:0]  row,
    output logic [4:0]  col,
    output logic [31:0] M0_addr,
    output logic        M0_R_req,
    output logic [31:0] M1_addr,
    output logic        busy,
    output logic        finish
);
    typedef enum logic [3:0] {IDLE, LOAD, SET, READ, MULT, ROUND, ADD, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [3:0] tap_n;
    logic [1:0] tr, tc, tr_n, tc_n;
    logic [4:0] row_n, col_n;
    logic [6:0] flags_raw;
    assign busy   = state != IDLE && state != DONE;
    assign finish = state == DONE;
    // state and counter registers; tr/tc track tap/3 and tap%3 for window addressing
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            tap   <= 4'd0;
            tr    <= 2'd0;
            tc    <= 2'd0;
            row   <= 5'd0;
            col   <= 5'd0;
        end else begin
            state <= state_n;
            tap   <= tap_n;
            tr    <= tr_n;
            tc    <= tc_n;
            row   <= row_n;
            col   <= col_n;
        end
    end
    // next state and counters; a held busy cycle keeps everything frozen
    always_comb begin
        state_n = state;
        tap_n   = tap;
        tr_n    = tr;
        tc_n    = tc;
        row_n   = row;
        col_n   = col;
        if (!(busy && hold)) begin
            case (state)
                IDLE, DONE: if (start) begin
                    state_n = LOAD;
                    tap_n   = 4'd0;
                    tr_n    = 2'd0;
                    tc_n    = 2'd0;
                    row_n   = 5'd0;
                    col_n   = 5'd0;
                end
                LOAD: begin
                    state_n = tap == 4'd9 ? SET : LOAD;
                    tap_n   = tap == 4'd9 ? 4'd0 : tap + 4'd1;
                end
                SET: begin
                    state_n = READ;
                    tap_n   = 4'd0;
                    tr_n    = 2'd0;
                    tc_n    = 2'd0;
                end
                READ: begin
                    state_n = tap == 4'd8 ? MULT : READ;
                    tap_n   = tap == 4'd8 ? 4'd0 : tap + 4'd1;
                    tc_n    = tc == 2'd2 ? 2'd0 : tc + 2'd1;
                    tr_n    = tap == 4'd8 ? 2'd0 : tc == 2'd2 ? tr + 2'd1 : tr;
                end
                MULT: begin
                    state_n = ROUND;
                    tap_n   = 4'd0;
                end
                ROUND: begin
                    state_n = tap == 4'd8 ? ADD : ROUND;
                    tap_n   = tap == 4'd8 ? 4'd0 : tap + 4'd1;
                end
                ADD: begin
                    state_n = tap == 4'd8 ? WRITE : ADD;
                    tap_n   = tap == 4'd8 ? 4'd0 : tap + 4'd1;
                end
                WRITE: begin
                    tap_n = 4'd0;
                    if (col != 5'(OUT_W - 1)) begin
                        col_n   = col + 5'd1;
                        state_n = SET;
                    end else if (row != 5'(OUT_W - 1)) begin
                        col_n   = 5'd0;
                        row_n   = row + 5'd1;
                        state_n = SET;
                    end else begin
                        state_n = DONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // command flags and memory addresses decoded from the registered state
    always_comb begin
        flags_raw = state == SET   ? 7'b0000001 :
                    state == READ  ? 7'b0000010 :
                    state == MULT  ? 7'b0000100 :
                    state == ROUND ? 7'b0001000 :
                    state == ADD   ? 7'b0010000 :
                    state == WRITE ? 7'b0100000 :
                    state == LOAD  ? 7'b1000000 : 7'b0000000;
        cmd_flags = hold ? 7'b0000000 : flags_raw;
        M0_R_req  = cmd_flags[6] | cmd_flags[1];
        M0_addr   = state == LOAD ? (32'(WBASE) + 32'(tap)) << 2 :
                    state == READ ? ((32'(row) + 32'(tr)) * 32'(IMG_W) + 32'(col) + 32'(tc)) << 2 :
                    32'd0;
        M1_addr   = (32'(row) * 32'(OUT_W) + 32'(col)) << 2;
    end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: scoreboard bench comparing conv_ctrl command stream against a loop-based model
module tb_conv_ctrl;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, hold = 1'b0;
    logic [6:0]  cmd_flags;
    logic [3:0]  tap;
    logic [4:0]  row, col;
    logic [31:0] M0_addr, M1_addr;
    logic        M0_R_req, busy, finish;

    typedef struct {
        logic [6:0]  f;
        logic [3:0]  tap;
        logic [4:0]  row, col;
        logic [31:0] m0, m1;
        bit          ctap, cm0, cm1;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          passed = 0, total = 0, writes = 0;
    logic [31:0] last_m1 = 0;

    conv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .cmd_flags(cmd_flags), .tap(tap), .row(row), .col(col),
        .M0_addr(M0_addr), .M0_R_req(M0_R_req), .M1_addr(M1_addr),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int fbit, input int t, input int r, input int c,
                                input int m0, input int m1, input bit ctap);
        exp_t e;
        e.f    = 7'(1 << fbit);
        e.tap  = 4'(t);
        e.row  = 5'(r);
        e.col  = 5'(c);
        e.m0   = 32'(m0);
        e.m1   = 32'(m1);
        e.ctap = ctap;
        e.cm0  = fbit == 6 || fbit == 1;
        e.cm1  = fbit == 5;
        return e;
    endfunction

    // expected command stream of one full run, in issue order
    task automatic push_model();
        for (int t = 0; t < 10; t++) q.push_back(mk(6, t, 0, 0, (784 + t) * 4, 0, 1));
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++) begin
                q.push_back(mk(0, 0, r, c, 0, 0, 1));
                for (int t = 0; t < 9; t++)
                    q.push_back(mk(1, t, r, c, ((r + t / 3) * 28 + c + t % 3) * 4, 0, 1));
                q.push_back(mk(2, 0, r, c, 0, 0, 0));
                for (int t = 0; t < 9; t++) q.push_back(mk(3, t, r, c, 0, 0, 1));
                for (int t = 0; t < 9; t++) q.push_back(mk(4, t, r, c, 0, 0, 1));
                q.push_back(mk(5, 0, r, c, 0, (r * 26 + c) * 4, 0));
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_flags"}, 32'(cmd_flags), 0);
        chk({tag, "_req"}, 32'(M0_R_req), 0);
        chk({tag, "_m0"}, M0_addr, 0);
        chk({tag, "_m1"}, M1_addr, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_finish"}, 32'(finish), 0);
        chk({tag, "_tap"}, 32'(tap), 0);
        chk({tag, "_row"}, 32'(row), 0);
        chk({tag, "_col"}, 32'(col), 0);
    endtask

    // monitor: mask check during held busy cycles, otherwise pop and compare each issued command
    always @(negedge clk) begin
        if (hold && busy) begin
            total++;
            if (cmd_flags === 7'd0 && M0_R_req === 1'b0) passed++;
            else $display("FAIL hold_mask: flags=%b req=%b expected 0/0", cmd_flags, M0_R_req);
        end else if (|cmd_flags) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_cmd: flags=%b row=%0d col=%0d expected none", cmd_flags, row, col);
            end else begin
                me = q.pop_front();
                if (cmd_flags === me.f && row === me.row && col === me.col && M0_R_req === me.cm0 &&
                    (!me.ctap || tap === me.tap) && (!me.cm0 || M0_addr === me.m0) &&
                    (!me.cm1 || M1_addr === me.m1))
                    passed++;
                else
                    $display("FAIL cmd: got f=%b tap=%0d r=%0d c=%0d m0=%0d m1=%0d req=%b expected f=%b tap=%0d r=%0d c=%0d m0=%0d m1=%0d req=%b",
                             cmd_flags, tap, row, col, M0_addr, M1_addr, M0_R_req,
                             me.f, me.tap, me.row, me.col, me.m0, me.m1, me.cm0);
                if (cmd_flags[5]) begin
                    writes++;
                    last_m1 = M1_addr;
                end
            end
        end
    end

    // mode 0: fixed 5-cycle hold mid-ROUND; 1: start from DONE then abort at (10,3); 2: random holds
    task automatic do_run(input int mode);
        int rel, holds;
        bit aborted;
        push_model();
        writes  = 0;
        aborted = 0;
        start   = 1'b1;
        hold    = mode != 0;
        tick();
        start = 1'b0;
        rel   = 1;
        holds = 0;
        hold  = mode == 2;
        if (hold) holds++;
        chk("busy_after_start", 32'(busy), 1);
        chk("finish_cleared", 32'(finish), 0);
        while (!finish && rel < 25000) begin
            if (mode == 1 && row == 5'd10 && col == 5'd3) begin
                reset = 1'b0;
                tick();
                chk_idle("abort");
                q.delete();
                reset   = 1'b1;
                aborted = 1;
                break;
            end
            tick();
            rel++;
            if (finish) hold = 1'b0;
            else if (mode == 0) hold = rel >= 26 && rel <= 30;
            else if (mode == 2) hold = $urandom_range(0, 15) == 0;
            if (hold) holds++;
        end
        hold = 1'b0;
        if (mode == 1) begin
            chk("abort_reached", 32'(aborted), 1);
            return;
        end
        chk("finish_cycle", 32'(rel), 32'(20291 + holds));
        chk("write_count", 32'(writes), 676);
        chk("last_m1", last_m1, 2700);
        chk("queue_empty", 32'(q.size()), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("finish_held", 32'(finish), 1);
            chk("busy_done", 32'(busy), 0);
        end
    endtask

    initial begin
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b1;
        do_run(0);
        do_run(1);
        do_run(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
